// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638-style serial responder with a display RAM and an optional key scan readback.
// Key readback is enabled by defining TM1638_RESPONDER_KEY_READ_EN; without it, read commands are ignored.
module tm1638_responder #(
  parameter int unsigned w_digit     = 8,
  parameter int unsigned sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sio_clk,
  input  logic                 sio_stb,
  input  logic                 sio_data_in,
  output logic                 sio_data_out,
  output logic                 sio_data_oe,
  input  logic [7:0]           keys,
  output logic [8*w_digit-1:0] hgfedcba,
  output logic [w_digit-1:0]   led,
  output logic                 display_on,
  output logic [2:0]           brightness
);

  localparam int unsigned ram_depth = 16;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RKEYS} state_t;

  state_t state, state_next;

  logic [sync_stages-1:0] clk_sync, stb_sync, din_sync;
  logic                   clk_prev, stb_prev;
  logic                   clk_s, stb_s, din_s;
  logic                   stb_fall_c, stb_rise_c, clk_rise_c;
  logic                   byte_done_c;
  logic [7:0]             byte_c;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic [7:0]             ram [ram_depth];
  logic [3:0]             addr;
  logic                   fixed_addr;

  // Input synchronizers; left out of reset so releasing reset never creates a false edge.
  always_ff @(posedge clk) begin
    clk_sync <= {clk_sync[sync_stages-2:0], sio_clk};
    stb_sync <= {stb_sync[sync_stages-2:0], sio_stb};
    din_sync <= {din_sync[sync_stages-2:0], sio_data_in};
    clk_prev <= clk_sync[sync_stages-1];
    stb_prev <= stb_sync[sync_stages-1];
  end

  assign clk_s = clk_sync[sync_stages-1];
  assign stb_s = stb_sync[sync_stages-1];
  assign din_s = din_sync[sync_stages-1];

  // Edge detection; a strobe edge in the same cycle masks any clock edge.
  assign stb_fall_c  = stb_prev & ~stb_s;
  assign stb_rise_c  = ~stb_prev & stb_s;
  assign clk_rise_c  = ~clk_prev & clk_s & ~stb_s & ~stb_fall_c;
  assign byte_c      = {din_s, shift};
  assign byte_done_c = clk_rise_c && (state == CMD || state == WDATA) && (bit_cnt == 3'd7);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode: strobe edges dominate, otherwise decode the command byte.
  always_comb begin
    state_next = state;
    if (stb_rise_c) begin
      state_next = IDLE;
    end else if (stb_fall_c) begin
      state_next = CMD;
    end else if (byte_done_c && state == CMD) begin
      case (byte_c[7:6])
        2'b01: begin
          if (byte_c[1]) begin
`ifdef TM1638_RESPONDER_KEY_READ_EN
            state_next = RKEYS;
`else
            state_next = IDLE;
`endif
          end else begin
            state_next = WDATA;
          end
        end
        2'b11:   state_next = WDATA;
        default: state_next = IDLE;
      endcase
    end
  end

  // Byte assembly, command side effects and display RAM writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      addr       <= '0;
      fixed_addr <= 1'b0;
      display_on <= 1'b0;
      brightness <= '0;
      for (int i = 0; i < ram_depth; i++) ram[i] <= '0;
    end else begin
      if (stb_fall_c) begin
        bit_cnt <= '0;
      end else if (clk_rise_c && (state == CMD || state == WDATA)) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= byte_c[7:1];
      end
      if (byte_done_c) begin
        if (state == CMD) begin
          case (byte_c[7:6])
            2'b01: fixed_addr <= byte_c[2];
            2'b11: addr       <= byte_c[3:0];
            2'b10: begin
              display_on <= byte_c[3];
              brightness <= byte_c[2:0];
            end
            default: ;
          endcase
        end else begin
          ram[addr] <= byte_c;
          if (!fixed_addr) addr <= addr + 4'd1;
        end
      end
    end
  end

  // Even RAM bytes feed the digits, bit0 of odd bytes feeds the LEDs.
  for (genvar d = 0; d < w_digit; d++) begin : g_digit
    assign hgfedcba[8*d +: 8] = ram[2*d];
    assign led[d]             = ram[2*d+1][0];
  end

`ifdef TM1638_RESPONDER_KEY_READ_EN
  logic        clk_fall_c;
  logic [31:0] rd_bits;
  logic [5:0]  rd_cnt;

  assign clk_fall_c = clk_prev & ~clk_s & ~stb_s & ~stb_fall_c;

  // Key snapshot on entering RKEYS, then one bit per falling sio_clk, 32 bits then release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_bits      <= '0;
      rd_cnt       <= '0;
      sio_data_oe  <= 1'b0;
      sio_data_out <= 1'b0;
    end else if (stb_rise_c || stb_fall_c) begin
      sio_data_oe  <= 1'b0;
      sio_data_out <= 1'b0;
    end else if (byte_done_c && state == CMD && state_next == RKEYS) begin
      for (int n = 0; n < 4; n++) rd_bits[8*n +: 8] <= {3'b000, keys[n+4], 3'b000, keys[n]};
      rd_cnt <= '0;
    end else if (clk_fall_c && state == RKEYS) begin
      if (!rd_cnt[5]) begin
        sio_data_oe  <= 1'b1;
        sio_data_out <= rd_bits[rd_cnt[4:0]];
        rd_cnt       <= rd_cnt + 6'd1;
      end else begin
        sio_data_oe  <= 1'b0;
        sio_data_out <= 1'b0;
      end
    end
  end
`else
  // No readback: the DIO pin is never driven and the key inputs are ignored.
  logic unused_keys_c;
  assign unused_keys_c = ^keys;
  assign sio_data_oe   = 1'b0;
  assign sio_data_out  = 1'b0;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: directed scenarios plus random frames against a transaction-level model.
module tb_tm1638_responder;

  localparam int unsigned W  = 6;
  localparam int unsigned SS = 2;
`ifdef TM1638_RESPONDER_KEY_READ_EN
  localparam bit KEYRD = 1'b1;
`else
  localparam bit KEYRD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           sio_clk = 1'b1;
  logic           sio_stb = 1'b1;
  logic           sio_data_in = 1'b1;
  logic           sio_data_out;
  logic           sio_data_oe;
  logic [7:0]     keys = 8'h00;
  logic [8*W-1:0] hgfedcba;
  logic [W-1:0]   led;
  logic           display_on;
  logic [2:0]     brightness;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: RAM image, address pointer, mode and display control, plus frame phase.
  logic [7:0] m_ram [16];
  logic [3:0] m_addr;
  bit         m_fixed;
  bit         m_disp;
  logic [2:0] m_bright;
  int         m_phase;   // 0 expecting command, 1 writing data, 2 ignoring rest of frame
  logic [7:0] rd_bytes [4];

  tm1638_responder #(.w_digit(W), .sync_stages(SS)) dut (
    .clk(clk), .rst(rst), .sio_clk(sio_clk), .sio_stb(sio_stb),
    .sio_data_in(sio_data_in), .sio_data_out(sio_data_out), .sio_data_oe(sio_data_oe),
    .keys(keys), .hgfedcba(hgfedcba), .led(led),
    .display_on(display_on), .brightness(brightness)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr = 4'd0; m_fixed = 1'b0; m_disp = 1'b0; m_bright = 3'd0; m_phase = 2;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_phase == 0) begin
      case (b[7:6])
        2'b01: begin m_fixed = b[2]; m_phase = b[1] ? 2 : 1; end
        2'b11: begin m_addr = b[3:0]; m_phase = 1; end
        2'b10: begin m_disp = b[3]; m_bright = b[2:0]; m_phase = 2; end
        default: m_phase = 2;
      endcase
    end else if (m_phase == 1) begin
      m_ram[m_addr] = b;
      if (!m_fixed) m_addr = 4'((32'(m_addr) + 1) % 16);
    end
  endtask

  function automatic logic key_bit(input int k);
    int byte_i = k / 8;
    int pos    = k % 8;
    if (pos == 0) return keys[byte_i];
    if (pos == 4) return keys[byte_i + 4];
    return 1'b0;
  endfunction

  // Every-cycle comparison of the visible display state against the model.
  always @(negedge clk) begin : cmp
    logic [8*W-1:0] es;
    logic [W-1:0]   el;
    if (chk_en) begin
      for (int d = 0; d < int'(W); d++) begin
        es[8*d +: 8] = m_ram[2*d];
        el[d]        = m_ram[2*d+1][0];
      end
      check("segments", 64'(hgfedcba), 64'(es));
      check("led", 64'(led), 64'(el));
      check("display_on", 64'(display_on), 64'(m_disp));
      check("brightness", 64'(brightness), 64'(m_bright));
      if (!KEYRD) begin
        check("oe_idle", 64'(sio_data_oe), 64'd0);
        check("dout_idle", 64'(sio_data_out), 64'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int ph();
    return int'(SS) + 2 + int'($urandom_range(0, 2));
  endfunction

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sio_clk = 1'b0; sio_data_in = b[i]; cyc(ph());
      if (i == 7) chk_en = 1'b0;
      sio_clk = 1'b1; cyc(ph());
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    send_bits(b, 8);
    model_byte(b);
    chk_en = 1'b1;
  endtask

  task automatic start_frame();
    sio_stb = 1'b0; m_phase = 0; cyc(int'(SS) + 3);
  endtask

  task automatic end_frame();
    sio_data_in = 1'b1; cyc(2);
    sio_stb = 1'b1; cyc(int'(SS) + 4);
    check("oe_after_stb", 64'(sio_data_oe), 64'd0);
  endtask

  // Read command followed by nclk serial clocks, checking drive enable and each key bit.
  task automatic do_read(input logic [7:0] cmd, input int nclk);
    logic exp_oe;
    wr_byte(cmd);
    for (int k = 0; k < nclk; k++) begin
      exp_oe = KEYRD && (k < 32);
      sio_clk = 1'b0; sio_data_in = 1'b1; cyc(ph());
      check("read_oe_low", 64'(sio_data_oe), 64'(exp_oe));
      if (exp_oe) begin
        check("key_bit", 64'(sio_data_out), 64'(key_bit(k)));
        rd_bytes[k / 8][k % 8] = sio_data_out;
      end
      sio_clk = 1'b1; cyc(ph());
      check("read_oe_high", 64'(sio_data_oe), 64'(exp_oe));
    end
  endtask

  task automatic pin_zero(input string tag);
    check({tag, "_seg"}, 64'(hgfedcba), 64'd0);
    check({tag, "_led"}, 64'(led), 64'd0);
    check({tag, "_disp"}, 64'(display_on), 64'd0);
    check({tag, "_bright"}, 64'(brightness), 64'd0);
    check({tag, "_oe"}, 64'(sio_data_oe), 64'd0);
    check({tag, "_dout"}, 64'(sio_data_out), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    for (int n = 0; n < 4; n++) rd_bytes[n] = 8'h00;
    cyc(6);
    rst = 1'b1;
    @(negedge clk);
    pin_zero("reset");
    #1;
    chk_en = 1'b1;

    // Sequential fill of all 16 bytes, then verify the pointer wrapped to 0.
    start_frame(); wr_byte(8'h40); end_frame();
    start_frame(); wr_byte(8'hC0);
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    end_frame();
    check("fill_digits01", 64'(hgfedcba[15:0]), 64'h0200);
    check("fill_led01", 64'(led[1:0]), 64'd3);
    start_frame(); wr_byte(8'h40); wr_byte(8'hA5); end_frame();
    check("wrap_digit0", 64'(hgfedcba[7:0]), 64'hA5);

    // Fixed address mode: last byte wins, neighbour untouched.
    start_frame(); wr_byte(8'h44); end_frame();
    start_frame(); wr_byte(8'hC3); wr_byte(8'hAA); wr_byte(8'h55); end_frame();
    check("fixed_led1", 64'(led[1]), 64'd1);
    check("fixed_digit2", 64'(hgfedcba[23:16]), 64'h04);

    // Display control on then off.
    start_frame(); wr_byte(8'h8F); end_frame();
    check("disp_on", 64'(display_on), 64'd1);
    check("disp_bright", 64'(brightness), 64'd7);
    start_frame(); wr_byte(8'h80); end_frame();
    check("disp_off", 64'(display_on), 64'd0);
    check("disp_bright0", 64'(brightness), 64'd0);

    // Key readback with keys = 0x21.
    keys = 8'h21;
    start_frame(); do_read(8'h42, 32); end_frame();
`ifdef TM1638_RESPONDER_KEY_READ_EN
    check("read_byte0", 64'(rd_bytes[0]), 64'h01);
    check("read_byte1", 64'(rd_bytes[1]), 64'h10);
    check("read_byte2", 64'(rd_bytes[2]), 64'h00);
    check("read_byte3", 64'(rd_bytes[3]), 64'h00);
`endif

    // Partial byte is discarded; the next frame decodes normally.
    start_frame(); wr_byte(8'hC0); send_bits(8'hFF, 5); chk_en = 1'b1; end_frame();
    start_frame(); wr_byte(8'h40); wr_byte(8'h99); end_frame();
    check("after_partial_digit0", 64'(hgfedcba[7:0]), 64'h99);

    // Reset pulse during the third data byte aborts the frame.
    start_frame(); wr_byte(8'hC0); wr_byte(8'h11); wr_byte(8'h22);
    send_bits(8'h33, 3);
    sio_clk = 1'b0; sio_data_in = 1'b1; cyc(3);
    chk_en = 1'b0; rst = 1'b0; cyc(1); rst = 1'b1;
    model_reset();
    @(negedge clk);
    pin_zero("midreset");
    #1;
    chk_en = 1'b1;
    sio_clk = 1'b1; cyc(ph());
    wr_byte(8'h77); wr_byte(8'h66);
    end_frame();

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      int kind;
      int nb;
      kind = int'($urandom_range(0, 5));
      nb   = int'($urandom_range(0, 4));
      keys = 8'($urandom);
      start_frame();
      case (kind)
        0: begin
          wr_byte(8'h40 | 8'($urandom_range(0, 1) << 2));
          for (int i = 0; i < nb; i++) wr_byte(8'($urandom));
        end
        1: begin
          wr_byte(8'hC0 | 8'($urandom_range(0, 15)));
          for (int i = 0; i < nb; i++) wr_byte(8'($urandom));
        end
        2: wr_byte(8'h80 | 8'($urandom_range(0, 15)));
        3: do_read(8'h42 | 8'($urandom_range(0, 1) << 2), 32 + int'($urandom_range(0, 2)));
        4: begin
          wr_byte(8'hC0 | 8'($urandom_range(0, 15)));
          send_bits(8'($urandom), int'($urandom_range(1, 7)));
        end
        default: begin
          wr_byte(8'($urandom_range(0, 63)));
          wr_byte(8'($urandom));
        end
      endcase
      end_frame();
    end

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
